uart_tx_core: RTL and testbench

- Serial transmitter stage directly downstream of the AXI-Lite UART register wrapper.
- Consumes the wrapper's one-cycle `uart_tx_start` pulse, 8-bit `uart_tx_data` and 3-bit baud select.
- Produces the 8N1 serial line `tx` and returns `busy`, which the wrapper exposes in its STATUS register.
- Clocked from the system clock; bit timing comes from an internal divisor selected per frame.

---
 rtl/uart_tx_core.sv | 130 +++++++++++++
 tb/tb_uart_tx_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter with a per-frame baud divisor latched on accept.
// Define UART_TX_PARITY_EN to add a parity_odd input and a parity bit between data and stop.
module uart_tx_core #(
    parameter int CLK_FREQ  = 50000000,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [2:0] baud_sel,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd,
`endif
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    // Rounded divisors: (f + b/2) / b
    localparam logic [DIV_WIDTH-1:0] DIV_115200 = DIV_WIDTH'((CLK_FREQ + 57600) / 115200);
    localparam logic [DIV_WIDTH-1:0] DIV_9600   = DIV_WIDTH'((CLK_FREQ + 4800) / 9600);
    localparam logic [DIV_WIDTH-1:0] DIV_4800   = DIV_WIDTH'((CLK_FREQ + 2400) / 4800);
    localparam logic [DIV_WIDTH-1:0] DIV_2400   = DIV_WIDTH'((CLK_FREQ + 1200) / 2400);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n, div, div_n, sel_div;
    logic [2:0]           idx, idx_n;
    logic [7:0]           shift, shift_n;
    logic                 wrap, tx_n, busy_n, done_n, overrun_n;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign sel_div = (baud_sel == 3'd1) ? DIV_9600 :
                     (baud_sel == 3'd2) ? DIV_4800 :
                     (baud_sel == 3'd3) ? DIV_2400 : DIV_115200;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        div_n     = div;
        done_n    = 1'b0;
        overrun_n = start && busy;
        wrap      = cnt == div - 1'b1;
        if (state == IDLE) begin
            if (start) begin
                state_n = START;
                cnt_n   = '0;
                shift_n = data;
                div_n   = sel_div;
            end
        end else begin
            cnt_n = wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                case (state)
                    START: begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                    DATA: begin
                        shift_n = shift >> 1;
                        idx_n   = idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (idx == 3'd7) state_n = PARITY;
`else
                        if (idx == 3'd7) state_n = STOP;
`endif
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: state_n = STOP;
`endif
                    STOP: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
        // Outputs are registered from the next state so tx/busy change on the accept edge
        tx_n = 1'b1;
        if (state_n == START) tx_n = 1'b0;
        if (state_n == DATA) tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
        if (state_n == PARITY) tx_n = par;
`endif
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            div     <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            div     <= div_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
            overrun <= overrun_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else if (state == IDLE && start) par <= ^data ^ parity_odd;
    end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench; the DUT runs at CLK_FREQ=5 MHz so divisors are 43/521/1042/2083.
module tb_uart_tx_core;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] data;
    logic [2:0] baud_sel;
    logic       tx, busy, done, overrun;
`ifdef UART_TX_PARITY_EN
    logic       po = 1'b0;
`endif

    uart_tx_core #(.CLK_FREQ(5000000), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .baud_sel(baud_sel),
`ifdef UART_TX_PARITY_EN
        .parity_odd(po),
`endif
        .tx(tx), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] fb;
        int          div;
        int          nb;
        int          len;
        bit          done_e;
        int          gap;
    } frame_t;

    frame_t q[$];
    int tests = 0, failed = 0;
    int idle_bad = 0, glitch_bad = 0, ovr_cnt = 0, exp_ovr = 0;
    bit mon_en = 0;

    task automatic check(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    // Hand-computed divisors at 5 MHz: 43.40->43, 520.83->521, 1041.67->1042, 2083.33->2083
    function automatic int exp_div(input logic [2:0] s);
        case (s)
            3'd1: return 521;
            3'd2: return 1042;
            3'd3: return 2083;
            default: return 43;
        endcase
    endfunction

    function automatic frame_t mk(input logic [7:0] d, input logic [2:0] s, input int gap, input int len);
        frame_t f;
        f.div = exp_div(s);
`ifdef UART_TX_PARITY_EN
        f.nb = 11;
        f.fb = {1'b1, ^d ^ po, d, 1'b0};
`else
        f.nb = 10;
        f.fb = {1'b1, 1'b1, d, 1'b0};
`endif
        f.len    = (len < 0) ? f.nb * f.div : len;
        f.done_e = len < 0;
        f.gap    = gap;
        return f;
    endfunction

    // Monitor: one frame per busy interval, checked bit-by-bit against the popped expectation
    frame_t cur;
    bit     in_f = 0;
    int     cnt, bad_at, end_cyc = 0, cyc = 0;
    logic   prev_ovr = 1'b0;

    always @(negedge clk) begin
        bit ending;
        ending = 0;
        cyc++;
        if (mon_en) begin
            if (!in_f && busy === 1'b1) begin
                in_f = 1;
                cnt = 0;
                bad_at = -1;
                if (q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    cur = '{fb: 11'h7ff, div: 1, nb: 0, len: 0, done_e: 0, gap: -1};
                end else begin
                    cur = q.pop_front();
                    if (cur.gap >= 0) check("idle_gap", cyc - end_cyc, cur.gap);
                end
            end
            if (in_f) begin
                if (busy === 1'b1) begin
                    if (bad_at < 0 && (cnt / cur.div >= cur.nb || tx !== cur.fb[cnt / cur.div])) bad_at = cnt;
                    cnt++;
                end else begin
                    ending = 1;
                    in_f = 0;
                    end_cyc = cyc;
                    check("frame_bits_first_bad_cycle", bad_at, -1);
                    check("frame_len", cnt, cur.len);
                    check("frame_done", int'(done === 1'b1), int'(cur.done_e));
                end
            end
            if (busy !== 1'b1 && tx !== 1'b1) idle_bad++;
            if (done !== 1'b0 && !ending) glitch_bad++;
            if (overrun === 1'b1) begin
                ovr_cnt++;
                if (prev_ovr === 1'b1) glitch_bad++;
            end
            prev_ovr = overrun;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 30000) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n >= 30000), 0);
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [2:0] s, input int gap, input int len);
        q.push_back(mk(d, s, gap, len));
        data = d;
        baud_sel = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; data = '0; baud_sel = '0;
        tick();
        mon_en = 1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        repeat (100) tick();
        check("idle_100_violations", idle_bad + glitch_bad + ovr_cnt, 0);

        start_frame(8'hA5, 3'd0, -1, -1);
        wait_idle();
        tick();

        // Latched divisor/data must survive input changes mid-frame
        start_frame(8'h00, 3'd3, -1, -1);
        repeat (5000) tick();
        baud_sel = 3'd0;
        data = 8'hFF;
        wait_idle();
        tick();

        start_frame(8'h5A, 3'd1, -1, -1);
        repeat (1000) tick();
        data = 8'hFF;
        baud_sel = 3'd0;
        start = 1'b1;
        exp_ovr++;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (3) tick();

        start_frame(8'h81, 3'd0, -1, -1);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("done_wait_timeout", int'(n >= 2000), 0);
        start_frame(8'h3C, 3'd0, 1, -1);
        wait_idle();
        tick();

        start_frame(8'h6E, 3'd2, -1, -1);
        wait_idle();
        tick();
        start_frame(8'hC3, 3'd7, -1, -1);
        wait_idle();
        tick();

        // Reset 2000 cycles into a 9600-baud frame
        start_frame(8'h0F, 3'd1, -1, 2000);
        repeat (1999) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (5) tick();
        start_frame(8'h96, 3'd0, -1, -1);
        wait_idle();
        tick();

        rst = 1'b1;
        start = 1'b1;
        data = 8'h77;
        tick();
        rst = 1'b0;
        start = 1'b0;
        repeat (50) tick();
        check("rst_start_busy", int'(busy), 0);

`ifdef UART_TX_PARITY_EN
        po = 1'b0;
        start_frame(8'hA5, 3'd0, -1, -1);
        wait_idle();
        tick();
        po = 1'b1;
        start_frame(8'hA5, 3'd0, -1, -1);
        wait_idle();
        tick();
`endif

        repeat (5) tick();
        check("queue_left", q.size(), 0);
        check("idle_tx_violations", idle_bad, 0);
        check("done_overrun_glitches", glitch_bad, 0);
        check("overrun_pulses", ovr_cnt, exp_ovr);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
